// File: rtl/branch_cond_unit.sv
// branch_cond_unit: two-stage branch condition evaluator writing a flag bank; optional unsigned compares via `BRANCH_COND_UNSIGNED_EN
module branch_cond_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_FLAGS = 4,
  parameter int COND_LSB = 19,
  localparam int FSW = $clog2(NUM_FLAGS)
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic [31:0]           ir,
  input  logic [DATA_WIDTH-1:0] bus,
  input  logic                  con_in,
  input  logic [FSW-1:0]        wr_sel,
  input  logic [FSW-1:0]        rd_sel,
  input  logic                  flags_clr,
  input  logic                  cond_unsigned,
  output logic                  con_out,
  output logic                  con_valid,
  output logic                  busy
);
  logic                  s1_vld_q, s1_vld_d;
  logic [DATA_WIDTH-1:0] s1_bus_q, s1_bus_d;
  logic [2:0]            s1_code_q, s1_code_d;
  logic [FSW-1:0]        s1_sel_q, s1_sel_d;
  logic [NUM_FLAGS-1:0]  flags_q, flags_d;
  logic                  con_valid_q, con_valid_d;
  logic                  uns, neg, zero, res;
  logic                  unused_ir;
  assign unused_ir = ^ir;
`ifdef BRANCH_COND_UNSIGNED_EN
  logic s1_uns_q, s1_uns_d;
  // capture the unsigned request alongside the operand
  always_comb s1_uns_d = con_in ? cond_unsigned : s1_uns_q;
  // hold the unsigned request with the rest of stage 1
  always_ff @(posedge clk) s1_uns_q <= s1_uns_d;
  assign uns = s1_uns_q;
`else
  logic unused_uns;
  assign unused_uns = cond_unsigned;
  assign uns = 1'b0;
`endif
  // stage 1 capture: a new entry every cycle con_in is high and reset is released
  always_comb begin
    s1_vld_d  = clr_n & con_in;
    s1_bus_d  = con_in ? bus : s1_bus_q;
    s1_code_d = con_in ? ir[COND_LSB+2:COND_LSB] : s1_code_q;
    s1_sel_d  = con_in ? wr_sel : s1_sel_q;
  end
  // stage 2 evaluation of the condition code on the captured operand
  always_comb begin
    neg  = s1_bus_q[DATA_WIDTH-1];
    zero = s1_bus_q == '0;
    res  = s1_code_q == 3'b000 ? zero :
           s1_code_q == 3'b001 ? !zero :
           s1_code_q == 3'b010 ? (uns | !neg) :
           s1_code_q == 3'b011 ? (!uns & neg) :
           s1_code_q == 3'b100 ? (uns ? !zero : (!neg & !zero)) :
           s1_code_q == 3'b101 ? (uns ? zero : (neg | zero)) :
           s1_code_q == 3'b110;
  end
  // flag bank update: a clear discards the stage-1 entry, otherwise write the result
  always_comb begin
    flags_d     = flags_q;
    con_valid_d = s1_vld_q & !flags_clr;
    if (flags_clr) flags_d = '0;
    else if (s1_vld_q) flags_d[s1_sel_q] = res;
  end
  // state registers with synchronous active-low reset on control and flag state
  always_ff @(posedge clk) begin
    s1_bus_q  <= s1_bus_d;
    s1_code_q <= s1_code_d;
    s1_sel_q  <= s1_sel_d;
    if (!clr_n) begin
      s1_vld_q    <= 1'b0;
      flags_q     <= '0;
      con_valid_q <= 1'b0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      flags_q     <= flags_d;
      con_valid_q <= con_valid_d;
    end
  end
  assign con_out   = flags_q[rd_sel];
  assign con_valid = con_valid_q;
  assign busy      = s1_vld_q;
endmodule
